io_bus_responder: RTL and testbench

IO_BUS_RESPONDER -- requirements
Module: io_bus_responder

---
 rtl/io_bus_responder_pkg.sv | 24 ++
 rtl/io_tx_fifo.sv | 68 ++++++
 rtl/io_bus_responder.sv | 139 +++++++++++++
 tb/tb_io_bus_responder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_responder_pkg.sv
// Shared constants, read-source encoding and address helper for the IO bus responder.
package io_bus_responder_pkg;

  localparam logic [1:0] IO_REGION = 2'b11;
  localparam logic [2:0] OFF_UART  = 3'd0;
  localparam logic [2:0] OFF_CLK   = 3'd4;

  localparam int TX_DEPTH_DEFAULT    = 8;
  localparam int FULL_MARGIN_DEFAULT = 2;

  // Where cpu_din comes from in the cycle after an access
  typedef enum logic [1:0] {
    RD_RAM,
    RD_UART,
    RD_CLK,
    RD_ZERO
  } rd_src_e;

  // True when the decoded region bits select the IO window
  function automatic logic is_io_region(input logic [1:0] region);
    return region == IO_REGION;
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Byte-wide TX FIFO with drop-on-full, same-cycle pop/push pass and a registered near-full flag.
module io_tx_fifo #(
  parameter int DEPTH  = 8,
  parameter int MARGIN = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          near_full,
  output logic          drop
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH  = CW'(DEPTH - MARGIN);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_fire;
  logic          pop_fire;
  logic [CW-1:0] count_next;

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign pop_fire  = pop & ~empty;
  assign push_fire = push & (~full | pop_fire);
  assign drop      = push & ~push_fire;
  assign head      = empty ? 8'h00 : mem[rd_ptr];

  // Occupancy after this cycle's accepted push and pop
  always_comb begin
    count_next = count;
    case ({push_fire, pop_fire})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      near_full <= 1'b0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + AW'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_next;
      near_full <= (count_next >= THRESH);
    end
  end

  // Storage needs no reset; head is masked while empty
  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/io_bus_responder.sv
// CPU bus responder: RAM pass-through, UART RX/TX window and cycle-counter snapshot in IO space.
module io_bus_responder
  import io_bus_responder_pkg::*;
#(
  parameter int TX_DEPTH    = TX_DEPTH_DEFAULT,
  parameter int FULL_MARGIN = FULL_MARGIN_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  input  logic [7:0]  ram_dout,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_pop,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        io_buffer_full,
  output logic        program_stop,
  output logic        tx_overflow
);

  logic                        active;
  logic                        io_sel;
  logic                        io_rd;
  logic                        io_wr;
  logic [2:0]                  off;
  rd_src_e                     rd_src_d;
  rd_src_e                     rd_src_q;
  logic [1:0]                  byte_sel_q;
  logic [7:0]                  rx_byte_q;
  logic [31:0]                 cycle_count;
  logic [31:0]                 snapshot;
  logic                        push;
  logic [7:0]                  push_data;
  logic                        tx_empty;
  logic                        fifo_full;
  logic                        fifo_drop;
  logic [$clog2(TX_DEPTH):0]   fifo_count;
  logic                        stop_q;
  logic                        ovf_q;
  logic                        unused_ok;

  assign io_sel = is_io_region(cpu_a[17:16]);
  assign off    = cpu_a[2:0];
  assign io_rd  = active & io_sel & ~cpu_wr;
  assign io_wr  = active & io_sel & cpu_wr;

  assign rx_pop    = io_rd & (off == OFF_UART) & rx_valid;
  assign push      = io_wr & (((off == OFF_UART) & (cpu_dout != 8'h00)) | (off == OFF_CLK));
  assign push_data = (off == OFF_CLK) ? 8'h00 : cpu_dout;

  assign tx_valid     = ~tx_empty;
  assign program_stop = stop_q;
  assign tx_overflow  = ovf_q;

  assign unused_ok = ^{cpu_a[31:18], cpu_a[15:3], fifo_count, fifo_full};

  // The first cycle after reset release is ignored so a half-presented access cannot act
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) active <= 1'b0;
    else         active <= 1'b1;
  end

  // Decide what the next cycle's cpu_din should show for the current access
  always_comb begin
    rd_src_d = RD_RAM;
    if (active && io_sel) begin
      if (cpu_wr)                rd_src_d = RD_ZERO;
      else if (off == OFF_UART)  rd_src_d = RD_UART;
      else if (off >= OFF_CLK)   rd_src_d = RD_CLK;
      else                       rd_src_d = RD_ZERO;
    end
  end

  // Register the read select, byte lane, received byte and counter snapshot
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_src_q   <= RD_RAM;
      byte_sel_q <= 2'd0;
      rx_byte_q  <= 8'h00;
      snapshot   <= '0;
    end else begin
      rd_src_q   <= rd_src_d;
      byte_sel_q <= off[1:0];
      if (io_rd && (off == OFF_UART)) rx_byte_q <= rx_valid ? rx_data : 8'h00;
      if (io_rd && (off == OFF_CLK))  snapshot  <= cycle_count;
    end
  end

  // Free-running cycle counter, wraps at 2^32
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) cycle_count <= '0;
    else         cycle_count <= cycle_count + 32'd1;
  end

  // Return data mux; RAM data passes straight through
  always_comb begin
    cpu_din = 8'h00;
    case (rd_src_q)
      RD_RAM:  cpu_din = ram_dout;
      RD_UART: cpu_din = rx_byte_q;
      RD_CLK:  cpu_din = snapshot[8*byte_sel_q +: 8];
      default: cpu_din = 8'h00;
    endcase
  end

  // Sticky halt and overflow flags, cleared only by reset
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stop_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (io_wr && (off == OFF_CLK)) stop_q <= 1'b1;
      if (fifo_drop)                 ovf_q  <= 1'b1;
    end
  end

  io_tx_fifo #(
    .DEPTH  (TX_DEPTH),
    .MARGIN (FULL_MARGIN)
  ) u_tx_fifo (
    .clk       (clk_in),
    .rst_n     (rst_in),
    .push      (push),
    .push_data (push_data),
    .pop       (tx_ready),
    .head      (tx_data),
    .full      (fifo_full),
    .empty     (tx_empty),
    .count     (fifo_count),
    .near_full (io_buffer_full),
    .drop      (fifo_drop)
  );

endmodule

// File: tb/tb_io_bus_responder.sv
// Self-checking bench for io_bus_responder: queue-based reference model plus directed literal checks.
module tb_io_bus_responder;

  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;

  localparam int K_RAM  = 0;
  localparam int K_RX   = 1;
  localparam int K_SNAP = 2;
  localparam int K_ZERO = 3;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic [7:0]  ram_dout;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_pop;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        io_buffer_full;
  logic        program_stop;
  logic        tx_overflow;

  int n_vectors    = 0;
  int n_miscompares = 0;

  logic [7:0]  mq[$];
  logic [31:0] m_count;
  logic [31:0] m_snap;
  logic [7:0]  m_rx;
  int          m_kind;
  int          m_bsel;
  bit          m_active;
  bit          m_stop;
  bit          m_ovf;
  bit          m_nf;

  always #5 clk_in = ~clk_in;

  io_bus_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .cpu_a          (cpu_a),
    .cpu_wr         (cpu_wr),
    .cpu_dout       (cpu_dout),
    .cpu_din        (cpu_din),
    .ram_dout       (ram_dout),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_pop         (rx_pop),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .io_buffer_full (io_buffer_full),
    .program_stop   (program_stop),
    .tx_overflow    (tx_overflow)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, return at the falling edge
  task automatic applyStimulus(input logic rst, input logic [31:0] a, input logic wr,
                               input logic [7:0] dout, input logic rxv, input logic [7:0] rxd,
                               input logic txr);
    @(posedge clk_in);
    #1;
    rst_in   = rst;
    cpu_a    = a;
    cpu_wr   = wr;
    cpu_dout = dout;
    rx_valid = rxv;
    rx_data  = rxd;
    tx_ready = txr;
    ram_dout = a[7:0] ^ 8'h3C;
    @(negedge clk_in);
  endtask

  task automatic idle(input logic txr);
    applyStimulus(1'b1, 32'h0000_0100, 1'b0, 8'h00, 1'b0, 8'h00, txr);
  endtask

  task automatic ioWrite(input logic [2:0] o, input logic [7:0] d, input logic txr);
    applyStimulus(1'b1, 32'h0003_0000 + 32'(o), 1'b1, d, 1'b0, 8'h00, txr);
  endtask

  task automatic ioRead(input logic [2:0] o, input logic rxv, input logic [7:0] rxd, input logic txr);
    applyStimulus(1'b1, 32'h0003_0000 + 32'(o), 1'b0, 8'h00, rxv, rxd, txr);
  endtask

  // Reference model: compare every cycle, then advance by this cycle's inputs
  always @(negedge clk_in) begin
    logic       io;
    logic [2:0] o;
    logic [7:0] exp_din;
    logic [31:0] sh;
    logic       exp_pop;
    logic       pop;
    logic       push;
    logic       acc;
    logic [7:0] pdata;
    if (!rst_in) begin
      checkOutput("rst_cpu_din", {24'h0, cpu_din}, {24'h0, ram_dout});
      checkOutput("rst_rx_pop", {31'h0, rx_pop}, 32'h0);
      checkOutput("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      checkOutput("rst_tx_data", {24'h0, tx_data}, 32'h0);
      checkOutput("rst_io_buffer_full", {31'h0, io_buffer_full}, 32'h0);
      checkOutput("rst_program_stop", {31'h0, program_stop}, 32'h0);
      checkOutput("rst_tx_overflow", {31'h0, tx_overflow}, 32'h0);
      mq.delete();
      m_count  = '0;
      m_snap   = '0;
      m_rx     = 8'h00;
      m_kind   = K_RAM;
      m_bsel   = 0;
      m_active = 1'b0;
      m_stop   = 1'b0;
      m_ovf    = 1'b0;
      m_nf     = 1'b0;
    end else begin
      io = (cpu_a[17:16] == 2'b11);
      o  = cpu_a[2:0];
      sh = m_snap >> (8 * m_bsel);
      case (m_kind)
        K_RAM:   exp_din = ram_dout;
        K_RX:    exp_din = m_rx;
        K_SNAP:  exp_din = sh[7:0];
        default: exp_din = 8'h00;
      endcase
      exp_pop = m_active && io && !cpu_wr && (o == 3'd0) && rx_valid;
      checkOutput("cpu_din", {24'h0, cpu_din}, {24'h0, exp_din});
      checkOutput("rx_pop", {31'h0, rx_pop}, {31'h0, exp_pop});
      checkOutput("tx_valid", {31'h0, tx_valid}, {31'h0, mq.size() != 0});
      checkOutput("tx_data", {24'h0, tx_data}, {24'h0, (mq.size() != 0) ? mq[0] : 8'h00});
      checkOutput("io_buffer_full", {31'h0, io_buffer_full}, {31'h0, m_nf});
      checkOutput("program_stop", {31'h0, program_stop}, {31'h0, m_stop});
      checkOutput("tx_overflow", {31'h0, tx_overflow}, {31'h0, m_ovf});

      pop   = (mq.size() != 0) && tx_ready;
      push  = m_active && io && cpu_wr && (((o == 3'd0) && (cpu_dout != 8'h00)) || (o == 3'd4));
      pdata = (o == 3'd4) ? 8'h00 : cpu_dout;
      acc   = push && ((mq.size() < DEPTH) || pop);
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(pdata);
      if (push && !acc) m_ovf = 1'b1;
      m_nf = (mq.size() >= DEPTH - MARGIN);
      if (m_active && io && cpu_wr && (o == 3'd4)) m_stop = 1'b1;

      if (!m_active || !io)    m_kind = K_RAM;
      else if (cpu_wr)         m_kind = K_ZERO;
      else if (o == 3'd0)      m_kind = K_RX;
      else if (o >= 3'd4)      m_kind = K_SNAP;
      else                     m_kind = K_ZERO;
      m_bsel = int'(o[1:0]);
      if (m_active && io && !cpu_wr && (o == 3'd0)) m_rx = rx_valid ? rx_data : 8'h00;
      if (m_active && io && !cpu_wr && (o == 3'd4)) m_snap = m_count;
      m_count  = m_count + 32'd1;
      m_active = 1'b1;
    end
  end

  // Guard against a stalled run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_in   = 1'b0;
    cpu_a    = 32'h0000_0100;
    cpu_wr   = 1'b0;
    cpu_dout = 8'h00;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    ram_dout = 8'h3C;

    // Reset state
    applyStimulus(1'b0, 32'h0000_0100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("lit_reset_cpu_din", {24'h0, cpu_din}, 32'h3C);
    checkOutput("lit_reset_tx_valid", {31'h0, tx_valid}, 32'h0);
    applyStimulus(1'b0, 32'h0000_0100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    idle(1'b1);

    // TX path drops zero bytes
    ioWrite(3'd0, 8'h41, 1'b1);
    checkOutput("lit_tx_empty_before", {31'h0, tx_valid}, 32'h0);
    ioWrite(3'd0, 8'h00, 1'b1);
    checkOutput("lit_tx_first_valid", {31'h0, tx_valid}, 32'h1);
    checkOutput("lit_tx_first_byte", {24'h0, tx_data}, 32'h41);
    ioWrite(3'd0, 8'h42, 1'b1);
    checkOutput("lit_tx_zero_skipped", {31'h0, tx_valid}, 32'h0);
    idle(1'b1);
    checkOutput("lit_tx_second_byte", {24'h0, tx_data}, 32'h42);
    idle(1'b1);
    checkOutput("lit_tx_drained", {31'h0, tx_valid}, 32'h0);

    // UART receive with and without data
    ioRead(3'd0, 1'b1, 8'h5A, 1'b1);
    checkOutput("lit_rx_pop_pulse", {31'h0, rx_pop}, 32'h1);
    idle(1'b1);
    checkOutput("lit_rx_pop_single", {31'h0, rx_pop}, 32'h0);
    checkOutput("lit_rx_data", {24'h0, cpu_din}, 32'h5A);
    ioRead(3'd0, 1'b0, 8'h99, 1'b1);
    checkOutput("lit_rx_no_pop", {31'h0, rx_pop}, 32'h0);
    idle(1'b1);
    checkOutput("lit_rx_empty_data", {24'h0, cpu_din}, 32'h00);

    // Unmapped offsets and RAM-region writes have no effect
    ioRead(3'd2, 1'b1, 8'h77, 1'b1);
    checkOutput("lit_unmapped_no_pop", {31'h0, rx_pop}, 32'h0);
    ioWrite(3'd1, 8'h12, 1'b1);
    checkOutput("lit_unmapped_read", {24'h0, cpu_din}, 32'h00);
    applyStimulus(1'b1, 32'h0002_0000, 1'b1, 8'h34, 1'b0, 8'h00, 1'b1);
    idle(1'b1);
    checkOutput("lit_unmapped_no_tx", {31'h0, tx_valid}, 32'h0);

    // Fill with the UART stalled: near-full after six, drop on the ninth
    for (int i = 1; i <= 5; i++) ioWrite(3'd0, 8'(i), 1'b0);
    ioWrite(3'd0, 8'h06, 1'b0);
    checkOutput("lit_near_full_at5", {31'h0, io_buffer_full}, 32'h0);
    ioWrite(3'd0, 8'h07, 1'b0);
    checkOutput("lit_near_full_at6", {31'h0, io_buffer_full}, 32'h1);
    ioWrite(3'd0, 8'h08, 1'b0);
    ioWrite(3'd0, 8'h09, 1'b0);
    checkOutput("lit_no_overflow_at8", {31'h0, tx_overflow}, 32'h0);
    idle(1'b0);
    checkOutput("lit_overflow_at9", {31'h0, tx_overflow}, 32'h1);
    checkOutput("lit_head_after_fill", {24'h0, tx_data}, 32'h01);
    for (int i = 0; i < 10; i++) idle(1'b1);
    checkOutput("lit_overflow_sticky", {31'h0, tx_overflow}, 32'h1);

    // Counter snapshot: reset, count to 0x1F3, read the four bytes
    applyStimulus(1'b0, 32'h0000_0100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 32'h1F3; i++) idle(1'b0);
    ioRead(3'd4, 1'b0, 8'h00, 1'b0);
    ioRead(3'd5, 1'b0, 8'h00, 1'b0);
    checkOutput("lit_snap_byte0", {24'h0, cpu_din}, 32'hF3);
    ioRead(3'd6, 1'b0, 8'h00, 1'b0);
    checkOutput("lit_snap_byte1", {24'h0, cpu_din}, 32'h01);
    ioRead(3'd7, 1'b0, 8'h00, 1'b0);
    checkOutput("lit_snap_byte2", {24'h0, cpu_din}, 32'h00);
    idle(1'b0);
    checkOutput("lit_snap_byte3", {24'h0, cpu_din}, 32'h00);

    // Halt write, write after halt, then reset mid-transfer
    ioWrite(3'd4, 8'hEE, 1'b0);
    checkOutput("lit_stop_before", {31'h0, program_stop}, 32'h0);
    ioWrite(3'd0, 8'h55, 1'b0);
    checkOutput("lit_stop_set", {31'h0, program_stop}, 32'h1);
    checkOutput("lit_stop_tx_valid", {31'h0, tx_valid}, 32'h1);
    checkOutput("lit_stop_tx_zero", {24'h0, tx_data}, 32'h00);
    idle(1'b0);
    applyStimulus(1'b0, 32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'hC3, 1'b1);
    checkOutput("lit_midrst_tx_valid", {31'h0, tx_valid}, 32'h0);
    checkOutput("lit_midrst_stop", {31'h0, program_stop}, 32'h0);
    checkOutput("lit_midrst_rx_pop", {31'h0, rx_pop}, 32'h0);
    checkOutput("lit_midrst_cpu_din", {24'h0, cpu_din}, 32'h3C);
    ioWrite(3'd0, 8'h77, 1'b1);
    checkOutput("lit_release_empty", {31'h0, tx_valid}, 32'h0);
    idle(1'b1);
    checkOutput("lit_release_idle", {31'h0, tx_valid}, 32'h0);
    ioWrite(3'd0, 8'h66, 1'b1);
    idle(1'b1);
    checkOutput("lit_after_release_tx", {24'h0, tx_data}, 32'h66);
    idle(1'b1);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
